// File: rtl/multicycle_add_sub.sv
// -----------------------------------------------------------------------------
// multicycle_add_sub
//
// Two's-complement adder/subtractor that pushes CHUNK bits per clock through a
// single narrow ripple slice. The whole WIDTH-bit operation takes
// N = WIDTH/CHUNK cycles. Results and flags change only when an operation
// completes, so the caller never sees a partial sum.
//
// Parameters
//   WIDTH    operand/result width; a multiple of CHUNK, >= 2
//   CHUNK    bits added per clock (CHUNK == WIDTH gives one-cycle operation)
//
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   start      request, sampled only while busy = 0
//   subtract   0: a + b, 1: a - b (latched with start)
//   a, b       operands (latched with start)
//   busy       operation in progress
//   done       one-cycle pulse when sum/flags update
//   sum        result modulo 2^WIDTH
//   carryout   raw carry out of the MSB (for subtract: 1 = no borrow)
//   overflow   signed overflow (carry into MSB xor carry out of MSB)
//   zero       sum == 0
// -----------------------------------------------------------------------------
module multicycle_add_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;       // already inverted for subtract
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic             carry_q;
    logic [KW-1:0]    k_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             carryout_q;
    logic             overflow_q;
    logic             zero_q;

    // ------------------------------------------------------------------
    // Ripple slice: CHUNK full adders operating on chunk k of the latched
    // operands, carry-in taken from the carry register.
    // ------------------------------------------------------------------
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic [CHUNK:0]   c;

    assign a_chunk = a_q[int'(k_q) * CHUNK +: CHUNK];
    assign b_chunk = b_q[int'(k_q) * CHUNK +: CHUNK];
    assign c[0]    = carry_q;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        logic p;
        assign p        = a_chunk[i] ^ b_chunk[i];
        assign s_chunk[i] = p ^ c[i];
        assign c[i+1]   = (a_chunk[i] & b_chunk[i]) | (p & c[i]);
    end

    // On the last chunk c[CHUNK-1] is the carry into the MSB of the word
    // and c[CHUNK] the carry out of it.
    logic msb_carry_in;
    logic final_carry;
    assign msb_carry_in = c[CHUNK-1];
    assign final_carry  = c[CHUNK];

    // Accumulator with the current chunk merged in; on the last chunk this
    // is the complete result, so it can be published in the same edge.
    always_comb begin
        // NOTE: acc_d takes a full default before the partial overwrite so
        // every bit is assigned on every path and no latch is inferred.
        acc_d = acc_q;
        acc_d[int'(k_q) * CHUNK +: CHUNK] = s_chunk;
    end

    // ------------------------------------------------------------------
    // Control FSM and all state registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so
        // every register samples pre-edge values regardless of order.
        if (!reset_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            carry_q    <= 1'b0;
            k_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sum_q      <= '0;
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            // done is a pulse: cleared every edge unless set below.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        // Subtract is a + ~b + 1: invert b here, the +1
                        // enters as the initial carry.
                        b_q     <= b ^ {WIDTH{subtract}};
                        carry_q <= subtract;
                        acc_q   <= '0;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= final_carry;
                    k_q     <= k_q + 1'b1;
                    if (k_q == K_LAST) begin
                        sum_q      <= acc_d;
                        carryout_q <= final_carry;
                        overflow_q <= msb_carry_in ^ final_carry;
                        zero_q     <= ~|acc_d;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign carryout = carryout_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;

endmodule
